// File: rtl/tile_probe_arbiter_pkg.sv
// Shared game package: playfield bounds, level tile-type encodings and the
// solid-tile mask used by the level, collision and probe logic, plus the
// probe arbiter state encoding.
//
// Contents:
//   SCREEN_W, SCREEN_H  playfield size in pixels
//   TW                  tile-type field width
//   tileType_t          tile-type encodings
//   SOLID_MASK          bit t set means tile type t blocks movement
//   probeState_t        tile_probe_arbiter FSM states
//   isSolidTile()       lookup helper for level/collision users

package tile_probe_arbiter_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int TW         = 3;
    localparam int TILE_TYPES = 1 << TW;

    typedef enum logic [TW-1:0] {
        TILE_EMPTY    = 3'd0,
        TILE_GROUND   = 3'd1,
        TILE_BRICK    = 3'd2,
        TILE_STONE    = 3'd3,
        TILE_PIPE     = 3'd4,
        TILE_PLATFORM = 3'd5,
        TILE_DOOR     = 3'd6,
        TILE_WALL     = 3'd7
    } tileType_t;

    // Only the empty tile is passable.
    localparam logic [TILE_TYPES-1:0] SOLID_MASK = 8'b1111_1110;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4,
        S_RESP = 3'd5
    } probeState_t;

    function automatic logic isSolidTile(input logic [TW-1:0] tileType);
        return SOLID_MASK[tileType];
    endfunction

endpackage

// File: rtl/tile_probe_arbiter_rr.sv
// Round-robin grant for the tile probe arbiter.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset (pointer returns to 0)
//   req       per-channel request vector
//   accept    high on the cycle the current grant is taken
//   grant     one-hot grant, combinational from req and the pointer
//   grantIdx  binary index of the granted channel
//
// The search starts at rrPtr and wraps; after an accepted grant the pointer
// moves to the channel after the winner, so with every channel requesting
// each one is served once per N_CH grants.

module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] req,
    input  logic            accept,
    output logic [N_CH-1:0] grant,
    output logic [IW-1:0]   grantIdx
);

    logic [IW-1:0] rrPtr;
    logic          found;
    int            pos;
    logic [IW-1:0] posIdx;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        pos      = 0;
        posIdx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos = int'(rrPtr) + i;
            if (pos >= N_CH) begin
                pos = pos - N_CH;
            end
            posIdx = IW'(pos);
            if (!found && req[posIdx]) begin
                found          = 1'b1;
                grant[posIdx]  = 1'b1;
                grantIdx       = posIdx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrPtr <= '0;
        end else if (accept) begin
            rrPtr <= (grantIdx == IW'(N_CH - 1)) ? '0 : grantIdx + IW'(1);
        end
    end

endmodule

// File: rtl/tile_probe_arbiter.sv
// Tile probe arbiter: shares one level read port among N_CH entity channels.
// A granted channel's bounding box is probed at its four corners, one per
// cycle, and a 4-bit collision mask is returned to that channel.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   req_valid  per-channel probe request
//   req_ready  one-hot acceptance pulse
//   req_x/y    box top-left, channel c at [c*CW +: CW]
//   req_w/h    box size in pixels, channel c at [c*SW +: SW] (0 acts as 1)
//   rsp_valid  one-cycle result strobe per channel
//   rsp_mask   held corner mask per channel, bit 3-n for corner n
//   lvl_x/y    registered probe address to the level read port
//   lvl_type   tile type at lvl_x/lvl_y (combinational from the level)
//   busy       high whenever a probe is in flight
//   dbgState   current FSM state
//
// Handshake: a request transfers on a cycle where req_valid[c] and
// req_ready[c] are both high. req_ready is only raised in IDLE, for one
// channel, and never while reset is asserted; the requester keeps valid and
// its fields steady until that cycle.
//
// Timing: grant in cycle T, corners presented in T+1..T+4, rsp_valid in T+5.

module tile_probe_arbiter
#(
    parameter int N_CH     = 4,
    parameter int CW       = 10,
    parameter int SW       = 5,
    parameter int TW       = tile_probe_arbiter_pkg::TW,
    parameter logic [(1<<TW)-1:0] SOLID_MASK = tile_probe_arbiter_pkg::SOLID_MASK,
    parameter int SCREEN_W = tile_probe_arbiter_pkg::SCREEN_W,
    parameter int SCREEN_H = tile_probe_arbiter_pkg::SCREEN_H
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_CH-1:0]                   req_valid,
    output logic [N_CH-1:0]                   req_ready,
    input  logic [N_CH*CW-1:0]                req_x,
    input  logic [N_CH*CW-1:0]                req_y,
    input  logic [N_CH*SW-1:0]                req_w,
    input  logic [N_CH*SW-1:0]                req_h,
    output logic [N_CH-1:0]                   rsp_valid,
    output logic [N_CH*4-1:0]                 rsp_mask,
    output logic [CW-1:0]                     lvl_x,
    output logic [CW-1:0]                     lvl_y,
    input  logic [TW-1:0]                     lvl_type,
    output logic                              busy,
    output tile_probe_arbiter_pkg::probeState_t dbgState
);

    import tile_probe_arbiter_pkg::*;

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Bounds at CW+1 bits so that x+w-1 overflowing CW still reads as off-screen.
    localparam logic [CW:0]   SCREEN_W_L = (CW+1)'(SCREEN_W);
    localparam logic [CW:0]   SCREEN_H_L = (CW+1)'(SCREEN_H);
    localparam logic [CW-1:0] MAX_X      = CW'(SCREEN_W - 1);
    localparam logic [CW-1:0] MAX_Y      = CW'(SCREEN_H - 1);

    probeState_t   state;
    probeState_t   nextState;

    logic [N_CH-1:0] grant;
    logic [IW-1:0]   grantIdx;
    logic            accept;

    // Fields of the channel being granted this cycle.
    logic [CW-1:0]   gntX;
    logic [CW-1:0]   gntY;
    logic [SW-1:0]   gntW;
    logic [SW-1:0]   gntH;

    // Latched request.
    logic [CW-1:0]   boxX;
    logic [CW-1:0]   boxY;
    logic [SW-1:0]   boxW;
    logic [SW-1:0]   boxH;
    logic [IW-1:0]   chIdx;

    // Corner generation for the next lvl_x/lvl_y load.
    logic [1:0]      cornerSel;
    logic            loadCorner;
    logic [CW-1:0]   selX;
    logic [CW-1:0]   selY;
    logic [SW-1:0]   selW;
    logic [SW-1:0]   selH;
    logic [SW-1:0]   spanX;
    logic [SW-1:0]   spanY;
    logic [CW:0]     sumX;
    logic [CW:0]     sumY;
    logic            oobX;
    logic            oobY;
    logic [CW-1:0]   clampX;
    logic [CW-1:0]   clampY;

    // Out-of-bounds flag that travels with the presented corner.
    logic            cornerOob;
    logic            cornerHit;
    logic [3:1]      maskAcc;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign accept    = reset && (state == S_IDLE) && (|req_valid);
    assign req_ready = accept ? grant : '0;

    rr_arbiter #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      (req_valid),
        .accept   (accept),
        .grant    (grant),
        .grantIdx (grantIdx)
    );

    always_comb begin
        gntX = '0;
        gntY = '0;
        gntW = '0;
        gntH = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant[c]) begin
                gntX = req_x[c*CW +: CW];
                gntY = req_y[c*CW +: CW];
                gntW = req_w[c*SW +: SW];
                gntH = req_h[c*SW +: SW];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (accept) nextState = S_P0;
            S_P0:    nextState = S_P1;
            S_P1:    nextState = S_P2;
            S_P2:    nextState = S_P3;
            S_P3:    nextState = S_RESP;
            S_RESP:  nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Corner address: the corner for the following state is computed here
    // so lvl_x/lvl_y are registered and valid for the whole Pn cycle.
    // In IDLE the source is the granting channel, afterwards the latch.
    // ------------------------------------------------------------------
    always_comb begin
        cornerSel  = 2'd0;
        loadCorner = 1'b0;
        case (state)
            S_IDLE: begin cornerSel = 2'd0; loadCorner = accept; end
            S_P0:   begin cornerSel = 2'd1; loadCorner = 1'b1;   end
            S_P1:   begin cornerSel = 2'd2; loadCorner = 1'b1;   end
            S_P2:   begin cornerSel = 2'd3; loadCorner = 1'b1;   end
            default: begin cornerSel = 2'd0; loadCorner = 1'b0; end
        endcase

        selX = (state == S_IDLE) ? gntX : boxX;
        selY = (state == S_IDLE) ? gntY : boxY;
        selW = (state == S_IDLE) ? gntW : boxW;
        selH = (state == S_IDLE) ? gntH : boxH;

        // A zero size behaves as one pixel, so the far edge equals the near one.
        spanX = (selW == '0) ? '0 : selW - SW'(1);
        spanY = (selH == '0) ? '0 : selH - SW'(1);

        sumX = {1'b0, selX} + (cornerSel[0] ? (CW+1)'(spanX) : '0);
        sumY = {1'b0, selY} + (cornerSel[1] ? (CW+1)'(spanY) : '0);

        oobX   = (sumX >= SCREEN_W_L);
        oobY   = (sumY >= SCREEN_H_L);
        clampX = oobX ? MAX_X : sumX[CW-1:0];
        clampY = oobY ? MAX_Y : sumY[CW-1:0];
    end

    assign cornerHit = cornerOob | SOLID_MASK[lvl_type];

    // ------------------------------------------------------------------
    // State, request latch, probe address and mask registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            boxX      <= '0;
            boxY      <= '0;
            boxW      <= '0;
            boxH      <= '0;
            chIdx     <= '0;
            lvl_x     <= '0;
            lvl_y     <= '0;
            cornerOob <= 1'b0;
            maskAcc   <= '0;
            rsp_mask  <= '0;
        end else begin
            state <= nextState;

            if (accept) begin
                boxX  <= gntX;
                boxY  <= gntY;
                boxW  <= gntW;
                boxH  <= gntH;
                chIdx <= grantIdx;
            end

            if (loadCorner) begin
                lvl_x     <= clampX;
                lvl_y     <= clampY;
                cornerOob <= oobX | oobY;
            end

            // lvl_type is sampled at the end of each Pn; corner n lands in bit 3-n.
            // The last corner goes straight into the channel's mask so that
            // it changes on the same cycle rsp_valid rises.
            case (state)
                S_P0: maskAcc[3] <= cornerHit;
                S_P1: maskAcc[2] <= cornerHit;
                S_P2: maskAcc[1] <= cornerHit;
                S_P3: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (IW'(c) == chIdx) begin
                            rsp_mask[c*4 +: 4] <= {maskAcc, cornerHit};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid = '0;
        for (int c = 0; c < N_CH; c++) begin
            rsp_valid[c] = (state == S_RESP) && (IW'(c) == chIdx);
        end
    end

    assign busy     = (state != S_IDLE);
    assign dbgState = state;

endmodule

// File: tb/tb_tile_probe_arbiter.sv
// Self-checking bench for tile_probe_arbiter (default parameters).
// A small level model drives lvl_type from lvl_x/lvl_y: an optional floor of
// tile type 1 at y >= floorY and an optional tile type 2 at (0,0).

module tb_tile_probe_arbiter;

    import tile_probe_arbiter_pkg::*;

    localparam int N_CH = 4;
    localparam int CW   = 10;
    localparam int SW   = 5;
    localparam int NVEC = 9;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [N_CH-1:0]    req_valid;
    logic [N_CH-1:0]    req_ready;
    logic [N_CH*CW-1:0] req_x;
    logic [N_CH*CW-1:0] req_y;
    logic [N_CH*SW-1:0] req_w;
    logic [N_CH*SW-1:0] req_h;
    logic [N_CH-1:0]    rsp_valid;
    logic [N_CH*4-1:0]  rsp_mask;
    logic [CW-1:0]      lvl_x;
    logic [CW-1:0]      lvl_y;
    logic [2:0]         lvl_type;
    logic               busy;
    probeState_t        dbgState;

    logic [10:0]        floorY = 11'd2047;
    logic               tile2 = 1'b0;

    always #5 clk = ~clk;

    tile_probe_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .rsp_valid (rsp_valid),
        .rsp_mask  (rsp_mask),
        .lvl_x     (lvl_x),
        .lvl_y     (lvl_y),
        .lvl_type  (lvl_type),
        .busy      (busy),
        .dbgState  (dbgState)
    );

    function automatic logic [2:0] tileAt(input logic [9:0] x, input logic [9:0] y,
                                          input logic [10:0] fy, input logic t2);
        if (t2 && x == 10'd0 && y == 10'd0) return 3'd2;
        if ({1'b0, y} >= fy) return 3'd1;
        return 3'd0;
    endfunction

    assign lvl_type = tileAt(lvl_x, lvl_y, floorY, tile2);

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          checks = 0;
    int          failures = 0;
    logic [1:0]  expQ[$];
    logic [15:0] expMaskAll = '0;

    typedef struct {
        int ch;
        int x, y, w, h;
        int floorY;
        int tile2;
        int mask;
        int xLo, xHi, yLo, yHi;
    } probeVec_t;

    probeVec_t vecs[NVEC];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic setFields(input int ch, input int x, input int y, input int w, input int h);
        req_x[ch*CW +: CW] = CW'(x);
        req_y[ch*CW +: CW] = CW'(y);
        req_w[ch*SW +: SW] = SW'(w);
        req_h[ch*SW +: SW] = SW'(h);
    endtask

    // One complete probe on an otherwise idle arbiter.
    task automatic runProbe(input probeVec_t v);
        int waitCnt;
        @(posedge clk); #1;
        floorY = 11'(v.floorY);
        tile2  = (v.tile2 != 0);
        setFields(v.ch, v.x, v.y, v.w, v.h);
        req_valid[v.ch] = 1'b1;
        waitCnt = 0;
        @(negedge clk);
        while (req_ready[v.ch] !== 1'b1 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkVal($sformatf("grant_seen_ch%0d", v.ch), 32'(req_ready[v.ch]), 32'd1);
        checkVal($sformatf("grant_onehot_ch%0d", v.ch), 32'(req_ready), 32'd1 << v.ch);
        @(posedge clk); #1;
        req_valid[v.ch] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkVal($sformatf("lvl_x_p%0d_ch%0d", n, v.ch), 32'(lvl_x), (n % 2 == 1) ? v.xHi : v.xLo);
            checkVal($sformatf("lvl_y_p%0d_ch%0d", n, v.ch), 32'(lvl_y), (n >= 2) ? v.yHi : v.yLo);
            checkVal($sformatf("busy_p%0d", n), 32'(busy), 32'd1);
            checkVal($sformatf("no_rsp_p%0d", n), 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        checkVal($sformatf("rsp_valid_ch%0d", v.ch), 32'(rsp_valid), 32'd1 << v.ch);
        expMaskAll[v.ch*4 +: 4] = 4'(v.mask);
        checkVal($sformatf("rsp_mask_all_ch%0d", v.ch), 32'(rsp_mask), 32'(expMaskAll));
        @(negedge clk);
        checkVal("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        checkVal("idle_after_rsp", 32'(busy), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Test
    // ------------------------------------------------------------------
    logic [3:0] contMask[N_CH];
    int         grantNo;
    int         rspCount;
    int         lastCh;
    int         lastGrantCyc;
    bit         dropValid;
    logic [1:0] expCh;
    int         waitCnt;
    bit         sawRsp;

    initial begin
        //           ch  x     y    w   h   floorY tile2 mask     xLo  xHi  yLo  yHi
        vecs[0] = '{0,   32,   32, 16, 16, 2047,  0,    4'b0000, 32,  47,  32,  47};
        vecs[1] = '{1,   32,   40, 16, 16, 48,    0,    4'b0011, 32,  47,  40,  55};
        vecs[2] = '{2,   630,  32, 16, 16, 2047,  0,    4'b0101, 630, 639, 32,  47};
        vecs[3] = '{3,   0,    0,  0,  0,  2047,  1,    4'b1111, 0,   0,   0,   0};
        vecs[4] = '{0,   600,  470,16, 16, 2047,  0,    4'b0011, 600, 615, 470, 479};
        vecs[5] = '{1,   1015, 10, 16, 1,  2047,  0,    4'b1111, 639, 639, 10,  10};
        vecs[6] = '{2,   100,  200,1,  31, 230,   0,    4'b0011, 100, 100, 200, 230};
        vecs[7] = '{3,   624,  464,16, 16, 2047,  0,    4'b0000, 624, 639, 464, 479};
        vecs[8] = '{0,   0,    0,  16, 16, 2047,  1,    4'b1000, 0,   15,  0,   15};

        contMask[0] = 4'b0000;
        contMask[1] = 4'b0000;
        contMask[2] = 4'b0101;
        contMask[3] = 4'b1111;

        // Reset held with every channel requesting: nothing may be granted.
        req_valid = '0;
        req_x = '0; req_y = '0; req_w = '0; req_h = '0;
        setFields(0, 32, 32, 16, 16);
        setFields(1, 32, 40, 16, 16);
        setFields(2, 630, 32, 16, 16);
        setFields(3, 1015, 10, 16, 1);
        req_valid = 4'hF;
        repeat (2) @(negedge clk);
        checkVal("rst_req_ready", 32'(req_ready), 32'd0);
        checkVal("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkVal("rst_rsp_mask", 32'(rsp_mask), 32'd0);
        checkVal("rst_lvl_x", 32'(lvl_x), 32'd0);
        checkVal("rst_lvl_y", 32'(lvl_y), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_state", 32'(dbgState), 32'(S_IDLE));

        // Contention: grants 0,1,2,3,0 six cycles apart, one response each.
        expQ.push_back(2'd0);
        expQ.push_back(2'd1);
        expQ.push_back(2'd2);
        expQ.push_back(2'd3);
        expQ.push_back(2'd0);
        grantNo = 0; rspCount = 0; lastCh = 0; lastGrantCyc = -100; dropValid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int cyc = 0; cyc < 60 && rspCount < 5; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                if (expQ.size() == 0) begin
                    checkVal("cont_extra_grant", 32'(req_ready), 32'd0);
                end else begin
                    expCh = expQ.pop_front();
                    checkVal("cont_grant_ch", 32'(req_ready), 32'd1 << expCh);
                    checkVal("cont_grant_cycle", cyc, grantNo * 6);
                    lastCh = int'(expCh);
                    lastGrantCyc = cyc;
                    grantNo++;
                    if (expQ.size() == 0) dropValid = 1'b1;
                end
            end
            if (rsp_valid != '0) begin
                checkVal("cont_rsp_ch", 32'(rsp_valid), 32'd1 << lastCh);
                checkVal("cont_rsp_cycle", cyc, lastGrantCyc + 5);
                checkVal("cont_rsp_mask", 32'(rsp_mask[lastCh*4 +: 4]), 32'(contMask[lastCh]));
                rspCount++;
            end
            if (rspCount < 5) begin
                @(posedge clk); #1;
                if (dropValid) req_valid = '0;
            end
        end
        req_valid = '0;
        checkVal("cont_grant_count", grantNo, 32'd5);
        checkVal("cont_rsp_count", rspCount, 32'd5);
        expMaskAll = 16'hF500;
        checkVal("cont_masks_held", 32'(rsp_mask), 32'(expMaskAll));

        // Directed single-channel probes.
        for (int i = 0; i < NVEC; i++) begin
            runProbe(vecs[i]);
        end

        // Reset during P2 abandons the probe.
        @(posedge clk); #1;
        floorY = 11'd48;
        tile2  = 1'b0;
        setFields(1, 32, 40, 16, 16);
        req_valid[1] = 1'b1;
        waitCnt = 0;
        @(negedge clk);
        while (req_ready[1] !== 1'b1 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkVal("p2rst_grant", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("p2rst_in_p2", 32'(dbgState), 32'(S_P2));
        checkVal("p2rst_lvl_y", 32'(lvl_y), 32'd55);
        #2 reset = 1'b0;
        #1;
        checkVal("p2rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkVal("p2rst_rsp_mask", 32'(rsp_mask), 32'd0);
        checkVal("p2rst_lvl_x", 32'(lvl_x), 32'd0);
        checkVal("p2rst_lvl_y0", 32'(lvl_y), 32'd0);
        checkVal("p2rst_busy", 32'(busy), 32'd0);
        checkVal("p2rst_state", 32'(dbgState), 32'(S_IDLE));
        sawRsp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid != '0) sawRsp = 1'b1;
        end
        checkVal("p2rst_no_rsp", 32'(sawRsp), 32'd0);
        expMaskAll = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        runProbe(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
